rib_rr_arbiter: RTL and testbench
=================================

# rib_rr_arbiter

Bus-ownership arbiter for the RIB interconnect in the tinyriscv SoC. It replaces fixed master priority with urgent preemption, round-robin rotation and a burst limit. It chooses which of the NUM_M masters drives the slave side each cycle, and raises the core stall (hold) whenever the instruction-fetch master is not the owner. The grant is combinational from request plus registered state, so RIB keeps its single-cycle access.

## Interface
- NUM_M, 4: number of masters (2..8).
- FETCH_ID, 1: background fetch master; granted only when no other master wins.
- URGENT_ID, 3: preempting master (uart_debug); bypasses rotation and burst limit.
- MAX_BURST, 8: maximum consecutive grants to one round-robin master while another round-robin master waits (1..255).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NUM_M  per-master request; bit i = master i.
- gnt_o  out  NUM_M  one-hot grant, or all-zero.
- gnt_valid_o  out  1  OR of gnt_o.
- gnt_id_o  out  3  index of granted master; 0 when gnt_valid_o=0.
- hold_flag_o  out  1  1 when gnt_valid_o=1 and gnt_id_o≠FETCH_ID (stalls core pipeline).
- owner_change_o  out  1  registered one-cycle pulse: owner this cycle differs from owner last cycle.

## Operation
- RR set = masters other than FETCH_ID and URGENT_ID.
- State registers:
  - owner (id + valid)
  - rr_ptr (last RR master granted)
  - burst_cnt (8 bit)
  - prev_gnt
- Grant decision, in priority order, evaluated combinationally each cycle:
  1. If req_i[URGENT_ID]=1, grant URGENT_ID.
  2. Else, if owner is an RR master, still requesting, and either burst_cnt<MAX_BURST or no other RR master requests: keep owner.
  3. Else, if any RR master requests: grant the first requester scanning rr_ptr+1, rr_ptr+2, … modulo NUM_M, skipping non-RR ids.
  4. Else, if req_i[FETCH_ID]=1, grant FETCH_ID.
  5. Else, no grant.
- Clock update:
  - Owner is set to the granted master, or invalid when there is no grant.
  - burst_cnt:
    - New RR owner: set to 1.
    - Same RR owner retained: increment, saturating at 255.
    - Urgent, fetch or no grant: cleared to 0.
  - rr_ptr updates only when an RR master is newly granted by rule 3.
- Urgent preemption does not update rr_ptr. After urgent releases, a still-requesting previous RR owner is not kept by rule 2, because owner is no longer an RR master. Rotation therefore resumes from rr_ptr+1.
- A request dropped mid-burst frees ownership in the same cycle; the next candidate is granted combinationally.

## Timing
- Grant latency: 0 cycles; gnt_o responds combinationally to req_i in the same cycle.
- State updates on the rising edge of clk.
- owner_change_o is 1 cycle after the change.
- Reset (rst=0, asynchronous):
  - owner invalid, rr_ptr=NUM_M-1, burst_cnt=0, prev_gnt=0.
  - gnt_o, gnt_valid_o, gnt_id_o, hold_flag_o and owner_change_o are forced to 0 while rst=0.
- Reset deassertion mid-transfer: arbitration restarts as from an empty history; no grant is carried over.
- Simultaneous events:
  - Urgent and fetch requesting together: urgent wins.
  - Burst expiry and a new RR request in the same cycle: rotate.
  - Burst expiry with no other RR requester: keep owner; counter saturates.
- MAX_BURST=1: strict round-robin every cycle among contending RR masters.

## Structure
- Shared package / defines file holds:
  - ARB_ID_W=3
  - ARB_CNT_W=8
  - RR set mask, derived from NUM_M, FETCH_ID and URGENT_ID
- One natural sub-module: rr_pick, a combinational rotating-priority encoder. Inputs: request mask and rr_ptr. Outputs: id and valid.
- rib instantiates rib_rr_arbiter and uses gnt_id_o as its master mux select. hold_flag_o replaces rib's existing hold_flag_o path.

## Test plan
All scenarios use NUM_M=4, FETCH_ID=1, URGENT_ID=3, MAX_BURST=4.
- Reset: rst=0 with req_i=4'b1111 → gnt_o=0 and hold_flag_o=0. Release rst → same cycle gnt_o=4'b1000, hold_flag_o=1.
- Fetch only: req_i=4'b0010 for 10 cycles → gnt_o=4'b0010 every cycle, hold_flag_o=0, owner_change_o never asserted after the first cycle.
- Burst limit: req_i=4'b0111 held → grants follow m0 ×4, m2 ×4, m0 ×4; owner_change_o pulses one cycle after each switch; m1 never granted.
- Urgent preemption: during the m0 burst at cycle 2, assert req_i[3] for 3 cycles → gnt_o=4'b1000 for those 3 cycles; then m2 is granted (rotation resumes), not m0.
- Lone RR master: req_i=4'b0011 for 300 cycles → m0 granted continuously, burst_cnt saturates at 255, no rotation to m1.
- Async reset mid-burst: rst pulsed low for half a cycle during the m2 burst → outputs go to 0 immediately. After release with req_i=4'b0101 → m0 granted (rr_ptr=3 start).

Source files
------------

// File: rtl/rib_rr_arbiter_pkg.sv
// Shared types, widths and helpers for the RIB bus-ownership arbiter.
package rib_rr_arbiter_pkg;

    localparam int unsigned ARB_ID_W  = 3;
    localparam int unsigned ARB_CNT_W = 8;
    localparam int unsigned ARB_MAX_M = 1 << ARB_ID_W;

    typedef struct packed {
        logic                valid;
        logic [ARB_ID_W-1:0] id;
    } arb_owner_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_URGENT,
        SRC_KEEP,
        SRC_ROTATE,
        SRC_FETCH
    } arb_src_e;

    // Masters that take part in round-robin rotation: everyone but fetch and urgent.
    function automatic logic [ARB_MAX_M-1:0] rr_set_mask(input int unsigned num_m,
                                                         input int unsigned fetch_id,
                                                         input int unsigned urgent_id);
        logic [ARB_MAX_M-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < ARB_MAX_M; i++) begin
            if (i < num_m && i != fetch_id && i != urgent_id) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester after ptr, wrapping modulo NUM_M.
module rib_rr_arbiter_rr_pick
    import rib_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M = 4
) (
    input  logic [ARB_MAX_M-1:0] req,
    input  logic [ARB_ID_W-1:0]  ptr,
    output logic [ARB_ID_W-1:0]  id,
    output logic                 valid
);

    // Scan farthest-first so the nearest requester after ptr is the last write.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int k = int'(NUM_M); k >= 1; k--) begin
            logic [ARB_ID_W-1:0] idx;
            idx = ARB_ID_W'((int'(ptr) + k) % int'(NUM_M));
            if (req[idx]) begin
                id    = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_rr_arbiter.sv
// RIB bus-ownership arbiter: urgent preemption, round-robin with burst limit,
// fetch as background master. Grant is combinational from req_i and state.
module rib_rr_arbiter
    import rib_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_M     = 4,
    parameter int unsigned FETCH_ID  = 1,
    parameter int unsigned URGENT_ID = 3,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    req_i,
    output logic [NUM_M-1:0]    gnt_o,
    output logic                gnt_valid_o,
    output logic [ARB_ID_W-1:0] gnt_id_o,
    output logic                hold_flag_o,
    output logic                owner_change_o
);

    localparam logic [ARB_MAX_M-1:0] RR_MASK    = rr_set_mask(NUM_M, FETCH_ID, URGENT_ID);
    localparam logic [ARB_ID_W-1:0]  FETCH_IDX  = ARB_ID_W'(FETCH_ID);
    localparam logic [ARB_ID_W-1:0]  URGENT_IDX = ARB_ID_W'(URGENT_ID);
    localparam logic [ARB_CNT_W-1:0] BURST_LIM  = ARB_CNT_W'(MAX_BURST);

    arb_owner_t            owner_q;
    logic [ARB_ID_W-1:0]   rr_ptr_q;
    logic [ARB_CNT_W-1:0]  burst_cnt;
    logic [NUM_M-1:0]      prev_gnt;
    logic                  owner_change_q;

    logic [ARB_MAX_M-1:0]  req8;
    logic [ARB_MAX_M-1:0]  rr_req8;
    logic [ARB_MAX_M-1:0]  other_rr;
    logic [ARB_MAX_M-1:0]  gnt8;
    logic [ARB_ID_W-1:0]   pick_id;
    logic                  pick_valid;
    arb_src_e              src;
    logic [ARB_ID_W-1:0]   sel_id;

    assign req8     = ARB_MAX_M'(req_i);
    assign rr_req8  = req8 & RR_MASK;
    assign other_rr = rr_req8 & ~(ARB_MAX_M'(1) << owner_q.id);

    rib_rr_arbiter_rr_pick #(
        .NUM_M (NUM_M)
    ) u_rr_pick (
        .req   (rr_req8),
        .ptr   (rr_ptr_q),
        .id    (pick_id),
        .valid (pick_valid)
    );

    // Grant decision in priority order: urgent, keep burst, rotate, fetch.
    always_comb begin
        src    = SRC_NONE;
        sel_id = '0;
        if (req8[URGENT_IDX]) begin
            src    = SRC_URGENT;
            sel_id = URGENT_IDX;
        end else if (owner_q.valid && RR_MASK[owner_q.id] && rr_req8[owner_q.id] &&
                     (burst_cnt < BURST_LIM || other_rr == '0)) begin
            src    = SRC_KEEP;
            sel_id = owner_q.id;
        end else if (pick_valid) begin
            src    = SRC_ROTATE;
            sel_id = pick_id;
        end else if (req8[FETCH_IDX]) begin
            src    = SRC_FETCH;
            sel_id = FETCH_IDX;
        end
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        gnt_valid_o    = rst && (src != SRC_NONE);
        gnt_id_o       = gnt_valid_o ? sel_id : '0;
        gnt8           = gnt_valid_o ? (ARB_MAX_M'(1) << sel_id) : '0;
        gnt_o          = gnt8[NUM_M-1:0];
        hold_flag_o    = gnt_valid_o && (sel_id != FETCH_IDX);
        owner_change_o = owner_change_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q        <= '0;
            rr_ptr_q       <= ARB_ID_W'(NUM_M - 1);
            burst_cnt      <= '0;
            prev_gnt       <= '0;
            owner_change_q <= 1'b0;
        end else begin
            owner_q.valid  <= gnt_valid_o;
            owner_q.id     <= gnt_id_o;
            prev_gnt       <= gnt_o;
            owner_change_q <= (gnt_o != prev_gnt);
            if (src == SRC_ROTATE) begin
                rr_ptr_q <= sel_id;
            end
            case (src)
                SRC_ROTATE: burst_cnt <= ARB_CNT_W'(1);
                SRC_KEEP:   if (burst_cnt != '1) burst_cnt <= burst_cnt + ARB_CNT_W'(1);
                default:    burst_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter with NUM_M=4, FETCH_ID=1, URGENT_ID=3, MAX_BURST=4.
module tb_rib_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic       gnt_valid_o;
    logic [2:0] gnt_id_o;
    logic       hold_flag_o;
    logic       owner_change_o;

    int checks   = 0;
    int failures = 0;

    rib_rr_arbiter #(
        .NUM_M     (4),
        .FETCH_ID  (1),
        .URGENT_ID (3),
        .MAX_BURST (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .gnt_valid_o    (gnt_valid_o),
        .gnt_id_o       (gnt_id_o),
        .hold_flag_o    (hold_flag_o),
        .owner_change_o (owner_change_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check every output against an expected one-hot grant and owner-change flag.
    task automatic chk_outs(input string tag, input logic [3:0] eg, input logic eoc);
        logic [2:0] eid;
        eid = 3'd0;
        for (int i = 0; i < 4; i++) if (eg[i]) eid = 3'(i);
        chk({tag, "_gnt"},   32'(gnt_o),          32'(eg));
        chk({tag, "_valid"}, 32'(gnt_valid_o),    32'(|eg));
        chk({tag, "_id"},    32'(gnt_id_o),       32'(eid));
        chk({tag, "_hold"},  32'(hold_flag_o),    32'((|eg) && (eg != 4'b0010)));
        chk({tag, "_ochg"},  32'(owner_change_o), 32'(eoc));
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic eoc);
        @(negedge clk);
        req_i = r;
        #1;
        chk_outs(tag, eg, eoc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        req_i = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        req_i = 4'b1111;
        #12;
        chk_outs("rst_hold", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_outs("rst_release", 4'b1000, 1'b0);
        step("urg_vs_fetch", 4'b1010, 4'b1000, 1'b1);

        do_reset();
        for (int k = 1; k <= 10; k++) step("fetch", 4'b0010, 4'b0010, k == 2);

        do_reset();
        for (int k = 1; k <= 12; k++)
            step("burst", 4'b0111, (k <= 4 || k > 8) ? 4'b0001 : 4'b0100,
                 k == 2 || k == 6 || k == 10);

        do_reset();
        step("urg1", 4'b0111, 4'b0001, 1'b0);
        step("urg2", 4'b0111, 4'b0001, 1'b1);
        step("urg3", 4'b1111, 4'b1000, 1'b0);
        step("urg4", 4'b1111, 4'b1000, 1'b1);
        step("urg5", 4'b1111, 4'b1000, 1'b0);
        step("urg6", 4'b0111, 4'b0100, 1'b0);
        step("urg7", 4'b0111, 4'b0100, 1'b1);

        do_reset();
        for (int k = 1; k <= 300; k++) step("lone", 4'b0011, 4'b0001, k == 2);
        chk("lone_burst_sat", 32'(dut.burst_cnt), 32'd255);

        do_reset();
        for (int k = 1; k <= 6; k++)
            step("pre_ar", 4'b0101, (k <= 4) ? 4'b0001 : 4'b0100, k == 2 || k == 6);
        rst = 1'b0;
        #1;
        chk_outs("ar_low", 4'b0000, 1'b0);
        #4;
        rst = 1'b1;
        step("ar_post1", 4'b0101, 4'b0001, 1'b0);
        step("ar_post2", 4'b0101, 4'b0001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
